// File: rtl/stage_sequencer.sv
// stage_sequencer: top-level game flow controller.
//
// Owns the 4-bit game state seen by the compositor and gameplay logic, plus
// the per-stage resources (keys, hearts, invulnerability, stage-3 darkness).
// State changes are taken only on frame_tick so layers never switch
// mid-frame; gameplay pulses are applied in the cycle they arrive.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   frame_tick    one-cycle pulse per video frame
//   btn_enter     one-cycle debounced pulse
//   btn_back      one-cycle debounced pulse
//   key_pickup    one-cycle pulse, key collected
//   player_hit    one-cycle pulse, hazard/boss contact
//   boss_down     one-cycle pulse, boss defeated
//   at_door       level, player overlaps the door
//   state         game state (encoding in the table below)
//   key_find      keys collected this stage, saturates at 3
//   heart         remaining hearts
//   invuln        invulnerability window active
//   isDark        stage-3 darkness phase
//   stage_start   one-cycle pulse when a STAGE state becomes visible
//
// state        | meaning
// -------------+---------------------------------------------
// 0 TITLE      | title screen, enter starts, back shows staff
// 1 STAFF      | staff credits, enter/back return to title
// 2 STAGE1     | first stage, keys + door to clear
// 3 SUCCESS1   | stage 1 cleared screen, auto-advances
// 4 STAGE2     | second stage, keys + door to clear
// 5 SUCCESS2   | stage 2 cleared screen, auto-advances
// 6 STAGE3     | boss stage with darkness phases
// 7 SUCCESS3   | game cleared, enter returns to title
// 8 FAIL       | out of hearts, enter returns to title
`timescale 1ns/1ps
module stage_sequencer #(
    parameter int unsigned SUCCESS_FRAMES = 180,
    parameter int unsigned INVULN_FRAMES  = 60,
    parameter int unsigned HEARTS         = 3,
    parameter int unsigned DARK_PERIOD    = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_enter,
    input  logic       btn_back,
    input  logic       key_pickup,
    input  logic       player_hit,
    input  logic       boss_down,
    input  logic       at_door,
    output logic [3:0] state,
    output logic [1:0] key_find,
    output logic [1:0] heart,
    output logic       invuln,
    output logic       isDark,
    output logic       stage_start
);
    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

    localparam int unsigned FRAME_MAX = (SUCCESS_FRAMES > DARK_PERIOD) ? SUCCESS_FRAMES : DARK_PERIOD;
    localparam int unsigned FRAME_W   = $clog2(FRAME_MAX + 1);
    localparam int unsigned INV_W     = $clog2(INVULN_FRAMES + 1);
    localparam logic [FRAME_W-1:0] SUCCESS_LAST = FRAME_W'(SUCCESS_FRAMES - 1);
    localparam logic [FRAME_W-1:0] DARK_LAST    = FRAME_W'(DARK_PERIOD - 1);
    localparam logic [INV_W-1:0]   INV_LOAD     = INV_W'(INVULN_FRAMES);
    localparam logic [1:0]         HEART_INIT   = 2'(HEARTS);

    state_t             state_q, state_d;
    logic [1:0]         key_q, key_d;
    logic [1:0]         heart_q, heart_d;
    logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               invuln_q, invuln_d;
    logic               dark_q, dark_d;
    logic               start_q, start_d;
    logic               enter_q, enter_d;
    logic               back_q, back_d;
    logic               boss_q, boss_d;
    logic               enter_now, back_now, boss_now;
    logic               in_stage, changing, entering;

    function automatic logic is_stage(input state_t s);
        return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
    endfunction

    always_comb begin
        // A pulse coinciding with frame_tick counts for that tick.
        enter_now = enter_q | btn_enter;
        back_now  = back_q  | btn_back;
        boss_now  = boss_q  | boss_down;
        in_stage  = is_stage(state_q);

        state_d = state_q;
        if (frame_tick) begin
            case (state_q)
                ST_TITLE: begin
                    if (enter_now)     state_d = ST_STAGE1;
                    else if (back_now) state_d = ST_STAFF;
                end
                ST_STAFF: begin
                    if (enter_now || back_now) state_d = ST_TITLE;
                end
                ST_STAGE1: begin
                    if (heart_q == 2'd0)                   state_d = ST_FAIL;
                    else if (key_q == 2'd3 && at_door)     state_d = ST_SUCCESS1;
                end
                ST_STAGE2: begin
                    if (heart_q == 2'd0)                   state_d = ST_FAIL;
                    else if (key_q == 2'd3 && at_door)     state_d = ST_SUCCESS2;
                end
                ST_STAGE3: begin
                    if (heart_q == 2'd0) state_d = ST_FAIL;
                    else if (boss_now)   state_d = ST_SUCCESS3;
                end
                ST_SUCCESS1: begin
                    if (enter_now || frame_q == SUCCESS_LAST) state_d = ST_STAGE2;
                end
                ST_SUCCESS2: begin
                    if (enter_now || frame_q == SUCCESS_LAST) state_d = ST_STAGE3;
                end
                ST_SUCCESS3, ST_FAIL: begin
                    if (enter_now) state_d = ST_TITLE;
                end
                default: state_d = ST_TITLE;
            endcase
        end
        changing = (state_d != state_q);
        entering = changing && is_stage(state_d);

        enter_d = frame_tick ? 1'b0 : enter_now;
        back_d  = frame_tick ? 1'b0 : back_now;
        boss_d  = frame_tick ? 1'b0 : boss_now;

        key_d = key_q;
        if (in_stage && key_pickup && key_q != 2'd3) key_d = key_q + 2'd1;

        heart_d   = heart_q;
        inv_cnt_d = inv_cnt_q;
        if (frame_tick && inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - INV_W'(1);
        // A fresh hit reloads the window even on a tick cycle.
        if (in_stage && player_hit && inv_cnt_q == '0 && heart_q != 2'd0) begin
            heart_d   = heart_q - 2'd1;
            inv_cnt_d = INV_LOAD;
        end

        frame_d = frame_q;
        dark_d  = dark_q;
        if (frame_tick && (state_q == ST_SUCCESS1 || state_q == ST_SUCCESS2 || state_q == ST_STAGE3)) begin
            if (state_q == ST_STAGE3 && frame_q == DARK_LAST) begin
                frame_d = '0;
                dark_d  = ~dark_q;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end

        // Any state change (entering or leaving a stage) resets the timers.
        if (changing) begin
            frame_d   = '0;
            inv_cnt_d = '0;
        end
        if (entering) begin
            key_d  = '0;
            dark_d = 1'b0;
        end
        if (entering && state_d == ST_STAGE1) heart_d = HEART_INIT;
        if (state_d != ST_STAGE3) dark_d = 1'b0;

        invuln_d = (inv_cnt_d != '0);
        start_d  = entering;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_TITLE;
            key_q     <= '0;
            heart_q   <= HEART_INIT;
            inv_cnt_q <= '0;
            frame_q   <= '0;
            invuln_q  <= 1'b0;
            dark_q    <= 1'b0;
            start_q   <= 1'b0;
            enter_q   <= 1'b0;
            back_q    <= 1'b0;
            boss_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            heart_q   <= heart_d;
            inv_cnt_q <= inv_cnt_d;
            frame_q   <= frame_d;
            invuln_q  <= invuln_d;
            dark_q    <= dark_d;
            start_q   <= start_d;
            enter_q   <= enter_d;
            back_q    <= back_d;
            boss_q    <= boss_d;
        end
    end

    assign state       = state_q;
    assign key_find    = key_q;
    assign heart       = heart_q;
    assign invuln      = invuln_q;
    assign isDark      = dark_q;
    assign stage_start = start_q;
endmodule

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
module tb_stage_sequencer;
    localparam int SF = 180;
    localparam int IV = 60;
    localparam int HT = 3;
    localparam int DP = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, btn_enter, btn_back, key_pickup, player_hit, boss_down, at_door;
    logic [3:0] state;
    logic [1:0] key_find, heart;
    logic       invuln, isDark, stage_start;

    int total = 0;
    int bad   = 0;

    // Reference model: state number, resource counts, ticks spent in the
    // current state, and an absolute "invulnerable until tick" deadline.
    int m_state, m_keys, m_hearts, m_ticks, g_ticks, inv_until;
    bit m_dark, m_start, f_en, f_bk, f_bd;

    stage_sequencer #(
        .SUCCESS_FRAMES(SF), .INVULN_FRAMES(IV), .HEARTS(HT), .DARK_PERIOD(DP)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_enter(btn_enter),
        .btn_back(btn_back), .key_pickup(key_pickup), .player_hit(player_hit),
        .boss_down(boss_down), .at_door(at_door), .state(state),
        .key_find(key_find), .heart(heart), .invuln(invuln), .isDark(isDark),
        .stage_start(stage_start)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic bit is_stage(input int s);
        return (s == 2) || (s == 4) || (s == 6);
    endfunction

    task automatic model_reset();
        m_state = 0; m_keys = 0; m_hearts = HT; m_ticks = 0;
        g_ticks = 0; inv_until = 0;
        m_dark = 0; m_start = 0; f_en = 0; f_bk = 0; f_bd = 0;
    endtask

    task automatic model_step(input bit ft, input bit en_p, input bit bk_p, input bit kp,
                              input bit ph, input bit bd_p, input bit door);
        bit en, bk, bd, stg;
        int nxt, g_new;
        en = f_en | en_p;
        bk = f_bk | bk_p;
        bd = f_bd | bd_p;
        stg = is_stage(m_state);
        nxt = m_state;
        g_new = g_ticks + (ft ? 1 : 0);
        if (ft) begin
            case (m_state)
                0: nxt = en ? 2 : (bk ? 1 : 0);
                1: if (en || bk) nxt = 0;
                2, 4: begin
                    if (m_hearts == 0) nxt = 8;
                    else if (m_keys == 3 && door) nxt = m_state + 1;
                end
                6: begin
                    if (m_hearts == 0) nxt = 8;
                    else if (bd) nxt = 7;
                end
                3, 5: if (en || m_ticks + 1 >= SF) nxt = m_state + 1;
                default: if (en) nxt = 0;
            endcase
        end
        if (stg && kp && m_keys < 3) m_keys++;
        if (stg && ph && g_ticks >= inv_until && m_hearts > 0) begin
            m_hearts--;
            inv_until = g_new + IV;
        end
        m_start = 0;
        if (nxt != m_state) begin
            m_ticks = 0;
            inv_until = 0;
            if (is_stage(nxt)) begin
                m_keys = 0;
                m_start = 1;
                if (nxt == 2) m_hearts = HT;
            end
        end else if (ft) begin
            m_ticks++;
        end
        g_ticks = g_new;
        m_state = nxt;
        m_dark = (m_state == 6) && (((m_ticks / DP) % 2) == 1);
        if (ft) begin
            f_en = 0; f_bk = 0; f_bd = 0;
        end else begin
            f_en = en; f_bk = bk; f_bd = bd;
        end
    endtask

    task automatic check_outputs();
        chk("state", 32'(state), m_state);
        chk("key_find", 32'(key_find), m_keys);
        chk("heart", 32'(heart), m_hearts);
        chk("invuln", 32'(invuln), (g_ticks < inv_until) ? 1 : 0);
        chk("isDark", 32'(isDark), 32'(m_dark));
        chk("stage_start", 32'(stage_start), 32'(m_start));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_key"}, 32'(key_find), 0);
        chk({tag, "_heart"}, 32'(heart), HT);
        chk({tag, "_invuln"}, 32'(invuln), 0);
        chk({tag, "_dark"}, 32'(isDark), 0);
        chk({tag, "_start"}, 32'(stage_start), 0);
    endtask

    // One clock: drive pulses, advance the model, check just after the edge.
    task automatic cyc(input bit ft, input bit en, input bit bk, input bit kp,
                       input bit ph, input bit bd);
        frame_tick = ft; btn_enter = en; btn_back = bk;
        key_pickup = kp; player_hit = ph; boss_down = bd;
        model_step(ft, en, bk, kp, ph, bd, at_door);
        @(posedge clk);
        #1;
        check_outputs();
        frame_tick = 0; btn_enter = 0; btn_back = 0;
        key_pickup = 0; player_hit = 0; boss_down = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; frame_tick = 0; btn_enter = 0; btn_back = 0;
        key_pickup = 0; player_hit = 0; boss_down = 0; at_door = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 0;

        // TITLE -> STAGE1
        cyc(0, 1, 0, 0, 0, 0);
        chk("title_hold", 32'(state), 0);
        tick(1);
        chk("enter_stage1", 32'(state), 2);
        chk("stage1_start", 32'(stage_start), 1);
        chk("stage1_heart", 32'(heart), 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("start_one_cycle", 32'(stage_start), 0);

        // Keys saturate, door exit, SUCCESS1 auto-advance
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        chk("key_saturate", 32'(key_find), 3);
        at_door = 1;
        tick(1);
        chk("door_success1", 32'(state), 3);
        at_door = 0;
        tick(SF - 1);
        chk("success1_hold", 32'(state), 3);
        tick(1);
        chk("success1_auto", 32'(state), 4);
        chk("stage2_keys", 32'(key_find), 0);

        // Hits and invulnerability window in STAGE2
        cyc(0, 0, 0, 0, 1, 0);
        chk("hit1_heart", 32'(heart), 2);
        chk("hit1_invuln", 32'(invuln), 1);
        tick(10);
        cyc(0, 0, 0, 0, 1, 0);
        chk("hit_ignored", 32'(heart), 2);
        tick(IV - 11);
        chk("invuln_last", 32'(invuln), 1);
        tick(1);
        chk("invuln_over", 32'(invuln), 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("hit3_heart", 32'(heart), 1);

        // Random noise in STAGE2 with the door closed: no transition possible
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                1'b0, ($urandom_range(0, 7) == 0));
        end
        chk("stage2_stay", 32'(state), 4);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        at_door = 1;
        tick(1);
        chk("door_success2", 32'(state), 5);
        at_door = 0;
        tick($urandom_range(1, SF - 10));
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        chk("enter_stage3", 32'(state), 6);
        chk("stage3_heart_carry", 32'(heart), 1);

        // Hit plus boss on the last heart: FAIL wins
        cyc(0, 0, 0, 0, 1, 1);
        chk("last_heart", 32'(heart), 0);
        tick(1);
        chk("fail_priority", 32'(state), 8);
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        chk("fail_to_title", 32'(state), 0);

        // Fresh run to STAGE3 for darkness phases
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        chk("restart_heart", 32'(heart), 3);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        at_door = 1;
        tick(1);
        at_door = 0;
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        at_door = 1;
        tick(1);
        at_door = 0;
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        chk("stage3_again", 32'(state), 6);
        tick(DP - 1);
        chk("dark_before", 32'(isDark), 0);
        tick(1);
        chk("dark_on", 32'(isDark), 1);
        tick(DP - 1);
        chk("dark_still", 32'(isDark), 1);
        tick(1);
        chk("dark_off", 32'(isDark), 0);
        tick(DP);
        chk("dark_on2", 32'(isDark), 1);
        cyc(0, 0, 0, 0, 0, 1);
        tick(1);
        chk("boss_success3", 32'(state), 7);
        chk("success3_dark", 32'(isDark), 0);
        cyc(0, 1, 0, 0, 0, 0);
        tick(1);
        chk("success3_title", 32'(state), 0);

        // Enter and back on the tick itself: enter wins
        cyc(1, 1, 1, 0, 0, 0);
        chk("same_cycle_enter", 32'(state), 2);
        cyc(0, 0, 0, 1, 1, 0);
        chk("pickup_hit_key", 32'(key_find), 1);
        chk("pickup_hit_heart", 32'(heart), 2);

        // Asynchronous reset mid-stage
        #2;
        rst = 1;
        #1;
        chk_reset("mid_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Long random run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) at_door = ~at_door;
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
